// File: rtl/ex_muldiv_iter.sv
// Iterative multiply/divide unit for the execute stage: MULT(U), DIV(U), MADD(U), MSUB(U).
// Multiply finishes after MUL_LAT cycles; divide retires DIV_BITS quotient bits per cycle.
module ex_muldiv_iter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DIV_BITS = 2,
    parameter int unsigned MUL_LAT  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall,
    input  logic                  start,
    input  logic [2:0]            op_i,
    input  logic [DATA_W-1:0]     reg1,
    input  logic [DATA_W-1:0]     reg2,
    input  logic [2*DATA_W-1:0]   hilo_i,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned DivCycles = DATA_W / DIV_BITS;
    localparam int unsigned CntMax    = (MUL_LAT > DivCycles) ? MUL_LAT : DivCycles;
    localparam int unsigned CntW      = $clog2(CntMax + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [DATA_W-1:0]     a_q, a_d, b_q, b_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W:0]       rem_q, rem_d;
    logic [DATA_W-1:0]     quo_q, quo_d, dvs_q, dvs_d;
    logic                  qneg_q, qneg_d, rneg_q, rneg_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [2*DATA_W-1:0]   hilo_q, hilo_d;

    logic                  in_idle;
    logic [2:0]            src_op;
    logic [DATA_W-1:0]     src_a, src_b;
    logic [2*DATA_W-1:0]   src_acc, ext_a, ext_b, prod, mul_res;
    logic                  neg_a, neg_b, in_is_div;
    logic [DATA_W-1:0]     abs_a, abs_b;
    logic [DATA_W:0]       s_rem, step_rem;
    logic [DATA_W-1:0]     s_quo, s_dvs, step_quo, div_lo, div_hi;
    logic                  s_qneg, s_rneg;

    // In IDLE the datapath works on the live inputs so a 1-cycle multiply and
    // the first divide step can be folded into the latch cycle.
    always_comb begin
        in_idle = (state_q == StIdle);
        src_op  = in_idle ? op_i   : op_q;
        src_a   = in_idle ? reg1   : a_q;
        src_b   = in_idle ? reg2   : b_q;
        src_acc = in_idle ? hilo_i : acc_q;

        ext_a   = {{DATA_W{~src_op[0] & src_a[DATA_W-1]}}, src_a};
        ext_b   = {{DATA_W{~src_op[0] & src_b[DATA_W-1]}}, src_b};
        prod    = ext_a * ext_b;
        if (src_op[2]) begin
            mul_res = src_op[1] ? (src_acc - prod) : (src_acc + prod);
        end else begin
            mul_res = prod;
        end
    end

    always_comb begin
        in_is_div = (op_i[2:1] == 2'b01);
        neg_a     = ~op_i[0] & reg1[DATA_W-1];
        neg_b     = ~op_i[0] & reg2[DATA_W-1];
        abs_a     = neg_a ? -reg1 : reg1;
        abs_b     = neg_b ? -reg2 : reg2;

        s_rem  = in_idle ? '0            : rem_q;
        s_quo  = in_idle ? abs_a         : quo_q;
        s_dvs  = in_idle ? abs_b         : dvs_q;
        s_qneg = in_idle ? neg_a ^ neg_b : qneg_q;
        s_rneg = in_idle ? neg_a         : rneg_q;

        // Restoring division, DIV_BITS bits per clock.
        step_rem = s_rem;
        step_quo = s_quo;
        for (int i = 0; i < int'(DIV_BITS); i++) begin
            step_rem = {step_rem[DATA_W-1:0], step_quo[DATA_W-1]};
            step_quo = {step_quo[DATA_W-2:0], 1'b0};
            if (step_rem >= {1'b0, s_dvs}) begin
                step_rem    = step_rem - {1'b0, s_dvs};
                step_quo[0] = 1'b1;
            end
        end

        div_lo = s_qneg ? -step_quo : step_quo;
        div_hi = s_rneg ? -step_rem[DATA_W-1:0] : step_rem[DATA_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        cnt_d   = cnt_q;
        hilo_d  = hilo_q;
        busy    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    busy  = 1'b1;
                    op_d  = op_i;
                    a_d   = reg1;
                    b_d   = reg2;
                    acc_d = hilo_i;
                    if (in_is_div) begin
                        if (reg2 == '0) begin
                            hilo_d  = {reg1, {DATA_W{1'b1}}};
                            state_d = StDone;
                        end else begin
                            rem_d  = step_rem;
                            quo_d  = step_quo;
                            dvs_d  = abs_b;
                            qneg_d = neg_a ^ neg_b;
                            rneg_d = neg_a;
                            if (DivCycles == 1) begin
                                hilo_d  = {div_hi, div_lo};
                                state_d = StDone;
                            end else begin
                                cnt_d   = CntW'(DivCycles - 2);
                                state_d = StDiv;
                            end
                        end
                    end else if (MUL_LAT == 1) begin
                        hilo_d  = mul_res;
                        state_d = StDone;
                    end else begin
                        cnt_d   = CntW'(MUL_LAT - 2);
                        state_d = StMul;
                    end
                end
            end
            StMul: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    hilo_d  = mul_res;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDiv: begin
                busy  = 1'b1;
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == '0) begin
                    hilo_d  = {div_hi, div_lo};
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                if (!stall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A flushed operation must not leave its result behind.
        if (flush) begin
            state_d = StIdle;
            hilo_d  = hilo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            cnt_q   <= '0;
            hilo_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            cnt_q   <= cnt_d;
            hilo_q  <= hilo_d;
        end
    end

    assign hilo_o = hilo_q;
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Bench for ex_muldiv_iter: three instances (DIV_BITS 2/1/4) checked every cycle against
// a transaction-level model, plus directed cases with hand-computed results and latencies.
module tb_ex_muldiv_iter;

    localparam logic [2:0] OpMult = 3'b000, OpMultu = 3'b001, OpDiv = 3'b010, OpDivu = 3'b011;
    localparam logic [2:0] OpMadd = 3'b100, OpMsubu = 3'b111;

    logic        clk, rst, flush, stall, start;
    logic [2:0]  op_i;
    logic [31:0] reg1, reg2;
    logic [63:0] hilo_i;
    logic [2:0]  busy_w, done_w;
    logic [2:0][63:0] hilo_w;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    ex_muldiv_iter #(.DATA_W(32), .DIV_BITS(2), .MUL_LAT(2)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall), .start(start), .op_i(op_i),
        .reg1(reg1), .reg2(reg2), .hilo_i(hilo_i), .hilo_o(hilo_w[0]), .busy(busy_w[0]),
        .done(done_w[0]));
    ex_muldiv_iter #(.DATA_W(32), .DIV_BITS(1), .MUL_LAT(2)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall), .start(start), .op_i(op_i),
        .reg1(reg1), .reg2(reg2), .hilo_i(hilo_i), .hilo_o(hilo_w[1]), .busy(busy_w[1]),
        .done(done_w[1]));
    ex_muldiv_iter #(.DATA_W(32), .DIV_BITS(4), .MUL_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall), .start(start), .op_i(op_i),
        .reg1(reg1), .reg2(reg2), .hilo_i(hilo_i), .hilo_o(hilo_w[2]), .busy(busy_w[2]),
        .done(done_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // Reference result from plain arithmetic.
    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] acc);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (op[2:1] == 2'b01) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (op[0]) return {a % b, a / b};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        p = op[0] ? ({32'd0, a} * {32'd0, b}) : 64'(sa * sb);
        if (!op[2]) return p;
        return op[1] ? acc - p : acc + p;
    endfunction

    function automatic int op_lat(input int k, input logic [2:0] op, input logic [31:0] b);
        if (op[2:1] != 2'b01) return 2;
        if (b == 32'd0) return 1;
        case (k)
            0: return 16;
            1: return 32;
            default: return 8;
        endcase
    endfunction

    // Model: 0 = idle, 1 = working, 2 = result presented.
    int          m_mode [3] = '{0, 0, 0};
    int          m_left [3] = '{0, 0, 0};
    logic [63:0] m_hilo [3];
    logic [63:0] m_pend [3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_mode[k] = 0;
                m_hilo[k] = '0;
            end else if (flush) begin
                m_mode[k] = 0;
            end else if (m_mode[k] == 0) begin
                if (start) begin
                    m_pend[k] = ref_res(op_i, reg1, reg2, hilo_i);
                    m_left[k] = op_lat(k, op_i, reg2) - 1;
                    m_mode[k] = 1;
                    if (m_left[k] == 0) begin
                        m_mode[k] = 2;
                        m_hilo[k] = m_pend[k];
                    end
                end
            end else if (m_mode[k] == 1) begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    m_mode[k] = 2;
                    m_hilo[k] = m_pend[k];
                end
            end else if (!stall) begin
                m_mode[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("u%0d.busy", k), 64'(busy_w[k]),
                    64'((m_mode[k] == 1) || (m_mode[k] == 0 && start && !flush)));
                chk($sformatf("u%0d.done", k), 64'(done_w[k]), 64'(m_mode[k] == 2));
                chk($sformatf("u%0d.hilo", k), hilo_w[k], m_hilo[k]);
            end
        end
    end

    // Issue one op, track done for every instance over a bounded window.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] acc, input bit lit, input logic [63:0] exp_res,
                          input int exp_lat, input string nm);
        int lat [3];
        logic [63:0] res;
        lat = '{-1, -1, -1};
        res = '0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            start  = (c == 0);
            op_i   = (c == 0) ? op : 3'($urandom_range(7));
            reg1   = (c == 0) ? a : $urandom;
            reg2   = (c == 0) ? b : $urandom;
            hilo_i = (c == 0) ? acc : {$urandom, $urandom};
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (done_w[k] && lat[k] < 0) begin
                    lat[k] = c;
                    if (k == 0) res = hilo_w[0];
                end
            end
        end
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s.lat%0d", nm, k), 64'(lat[k]), 64'(op_lat(k, op, b)));
        if (lit) begin
            chk({nm, ".res"}, res, exp_res);
            chk({nm, ".lat_lit"}, 64'(lat[0]), 64'(exp_lat));
        end
    endtask

    initial begin
        int done_at;
        logic [31:0] ra, rb;
        rst = 1'b1; flush = 1'b0; stall = 1'b0; start = 1'b0;
        op_i = '0; reg1 = '0; reg2 = '0; hilo_i = '0;
        @(posedge clk);
        #1;
        chk_en = 1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset.u%0d.busy", k), 64'(busy_w[k]), 64'd0);
            chk($sformatf("reset.u%0d.done", k), 64'(done_w[k]), 64'd0);
            chk($sformatf("reset.u%0d.hilo", k), hilo_w[k], 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Pin the model itself.
        chk("model.mult", ref_res(OpMult, 32'hFFFF_FFFD, 32'd5, 64'd0), 64'hFFFF_FFFF_FFFF_FFF1);
        chk("model.div", ref_res(OpDiv, 32'hFFFF_FFF9, 32'd2, 64'd0), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model.ovf", ref_res(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0),
            64'h0000_0000_8000_0000);

        run_op(OpMult, 32'hFFFF_FFFD, 32'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFF1, 2, "mult");
        run_op(OpDivu, 32'd100, 32'd7, 64'd0, 1, 64'h0000_0002_0000_000E, 16, "divu");
        run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFD, 16, "div_neg");
        run_op(OpDiv, 32'd7, 32'hFFFF_FFFE, 64'd0, 1, 64'h0000_0001_FFFF_FFFD, 16, "div_negb");
        run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 1, 64'h0000_0000_8000_0000, 16,
               "div_ovf");
        run_op(OpDivu, 32'h1234, 32'd0, 64'd0, 1, 64'h0000_1234_FFFF_FFFF, 1, "divu_zero");
        run_op(OpDiv, 32'hFFFF_FFFF, 32'd0, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, "div_zero");
        run_op(OpMadd, 32'hFFFF_FFFF, 32'd2, 64'h10, 1, 64'h0000_0000_0000_000E, 2, "madd");
        run_op(OpMsubu, 32'd1, 32'd1, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 2, "msubu");
        run_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1, 64'hFFFF_FFFE_0000_0001, 2,
               "multu");

        // Flush mid-divide, then a new op on the first idle cycle.
        done_at = -1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #1;
            start = (c == 0) || (c == 6);
            flush = (c == 5);
            op_i  = (c == 6) ? OpMultu : OpDivu;
            reg1  = (c == 6) ? 32'd3 : 32'd1000;
            reg2  = (c == 6) ? 32'd4 : 32'd3;
            @(negedge clk);
            if (c <= 6) chk($sformatf("flush.done_c%0d", c), 64'(done_w[0]), 64'd0);
            if (done_w[0] && done_at < 0) begin
                done_at = c;
                chk("flush.new_res", hilo_w[0], 64'd12);
            end
        end
        chk("flush.new_lat", 64'(done_at), 64'd8);

        // Stall held in DONE for three cycles.
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            start = (c == 0);
            op_i  = OpMult;
            reg1  = 32'd7;
            reg2  = 32'd6;
            stall = (c >= 2 && c <= 4);
            @(negedge clk);
            chk($sformatf("stall.done_c%0d", c), 64'(done_w[0]), 64'((c >= 2 && c <= 5) ? 1 : 0));
            if (c >= 2 && c <= 5) chk($sformatf("stall.hilo_c%0d", c), hilo_w[0], 64'd42);
        end

        // Reset in the middle of a divide.
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            start = (c == 0);
            op_i  = OpDivu;
            reg1  = 32'd1000;
            reg2  = 32'd3;
            rst   = (c == 5);
            @(negedge clk);
            if (c == 6) begin
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("rst.u%0d.busy", k), 64'(busy_w[k]), 64'd0);
                    chk($sformatf("rst.u%0d.done", k), 64'(done_w[k]), 64'd0);
                    chk($sformatf("rst.u%0d.hilo", k), hilo_w[k], 64'd0);
                end
            end
        end

        // Random sweep with corner operands mixed in.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(4))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(15));
                default: rb = $urandom;
            endcase
            run_op(3'($urandom_range(7)), ra, rb, {$urandom, $urandom}, 0, 64'd0, 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
